// File: rtl/num_2_ascii_encoder_pkg.sv
// ============================================================================
// Package     : num_ascii_pkg
// Description : Shared constants and state encoding for the decimal ASCII encoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package num_ascii_pkg;

    localparam int          BIN_W       = 16;
    localparam int          DIG_N       = 5;
    localparam int          BCD_W       = 4 * DIG_N;
    localparam logic [7:0]  ASCII_ZERO  = 8'h30;
    localparam logic [7:0]  ASCII_MINUS = 8'h2D;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONV   = 3'd1,
        SIGN   = 3'd2,
        DIGITS = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/num_2_ascii_encoder_if.sv
// ============================================================================
// Interface   : num_2_ascii_encoder_if
// Description : Request and byte-stream signals of the decimal ASCII encoder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface num_2_ascii_encoder_if #(
    parameter int BIN_W = 16
);
    logic             Start;
    logic             Signed_In;
    logic [BIN_W-1:0] Bin_In;
    logic             Busy;
    logic [7:0]       ASCII_Out;
    logic             ASCII_Valid;
    logic             ASCII_Ready;
    logic             Done;

    modport master (
        input  Start, Signed_In, Bin_In, ASCII_Ready,
        output Busy, ASCII_Out, ASCII_Valid, Done
    );

    modport slave (
        output Start, Signed_In, Bin_In, ASCII_Ready,
        input  Busy, ASCII_Out, ASCII_Valid, Done
    );
endinterface

`default_nettype wire

// File: rtl/num_2_ascii_encoder_bcd_add3.sv
// ============================================================================
// Module      : bcd_add3
// Description : Double-dabble nibble corrector (adds 3 when the digit is >= 5).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bcd_add3 (
    input  wire logic [3:0] i_nib,
    output logic      [3:0] o_nib
);
    assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;
endmodule

`default_nettype wire

// File: rtl/num_2_ascii_encoder.sv
// ============================================================================
// Module      : num_2_ascii_encoder
// Description : 16-bit binary to decimal ASCII byte stream, double-dabble + emitter.
//               NUM2ASCII_LZS_EN enables leading-zero suppression.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module num_2_ascii_encoder
    import num_ascii_pkg::*;
#(
    parameter int BIN_W = 16,
    parameter int DIG_N = 5
) (
    input wire logic              Encoder_Clk,
    input wire logic              Encoder_Clr,
    num_2_ascii_encoder_if.master bus
);
    localparam int L_BCD_W = 4 * DIG_N;

    state_t               r_state, w_state_nxt;
    logic [BIN_W-1:0]     r_mag, w_mag_nxt, w_mag_conv;
    logic [L_BCD_W-1:0]   r_bcd, w_bcd_nxt, w_bcd_adj, w_bcd_conv;
    logic                 r_neg, w_neg_nxt;
    logic [4:0]           r_step, w_step_nxt;
    logic [2:0]           r_idx, w_idx_nxt, w_lead;
    logic [7:0]           r_ascii, w_ascii_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 w_acc;
    logic                 w_neg_in;

    generate
        for (genvar gi = 0; gi < DIG_N; gi++) begin : g_add3
            bcd_add3 u_add3 (
                .i_nib (r_bcd[4*gi +: 4]),
                .o_nib (w_bcd_adj[4*gi +: 4])
            );
        end
    endgenerate

    assign {w_bcd_conv, w_mag_conv} = {w_bcd_adj, r_mag} << 1;

`ifdef NUM2ASCII_LZS_EN
    // Highest nonzero digit of the finished conversion; 0 when the value is 0.
    always_comb begin
        w_lead = 3'd0;
        for (int i = 0; i < DIG_N; i++) begin
            if (w_bcd_conv[4*i +: 4] != 4'd0) w_lead = 3'(i);
        end
    end
`else
    assign w_lead = 3'(DIG_N - 1);
`endif

    function automatic logic [7:0] f_digit(input logic [L_BCD_W-1:0] b, input logic [2:0] idx);
        logic [L_BCD_W-1:0] t;
        t = b >> {idx, 2'b00};
        return ASCII_ZERO + {4'h0, t[3:0]};
    endfunction

    assign w_acc    = r_valid & bus.ASCII_Ready;
    assign w_neg_in = bus.Signed_In & bus.Bin_In[BIN_W-1];

    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_bcd_nxt   = r_bcd;
        w_neg_nxt   = r_neg;
        w_step_nxt  = r_step;
        w_idx_nxt   = r_idx;
        w_ascii_nxt = r_ascii;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.Start) begin
                    w_neg_nxt   = w_neg_in;
                    w_mag_nxt   = w_neg_in ? (~bus.Bin_In + BIN_W'(1)) : bus.Bin_In;
                    w_bcd_nxt   = '0;
                    w_step_nxt  = 5'd0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = CONV;
                end
            end
            CONV: begin
                w_bcd_nxt  = w_bcd_conv;
                w_mag_nxt  = w_mag_conv;
                w_step_nxt = r_step + 5'd1;
                if (r_step == 5'(BIN_W - 1)) begin
                    w_idx_nxt   = w_lead;
                    w_valid_nxt = 1'b1;
                    if (r_neg) begin
                        w_state_nxt = SIGN;
                        w_ascii_nxt = ASCII_MINUS;
                    end else begin
                        w_state_nxt = DIGITS;
                        w_ascii_nxt = f_digit(w_bcd_conv, w_lead);
                    end
                end
            end
            SIGN: begin
                if (w_acc) begin
                    w_state_nxt = DIGITS;
                    w_ascii_nxt = f_digit(r_bcd, r_idx);
                end
            end
            DIGITS: begin
                if (w_acc) begin
                    if (r_idx == 3'd0) begin
                        w_state_nxt = DONE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx - 3'd1;
                        w_ascii_nxt = f_digit(r_bcd, r_idx - 3'd1);
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Encoder_Clk) begin
        if (Encoder_Clr) begin
            r_state <= IDLE;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_step  <= 5'd0;
            r_idx   <= 3'd0;
            r_ascii <= 8'h00;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mag   <= w_mag_nxt;
            r_bcd   <= w_bcd_nxt;
            r_neg   <= w_neg_nxt;
            r_step  <= w_step_nxt;
            r_idx   <= w_idx_nxt;
            r_ascii <= w_ascii_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.Busy        = r_busy;
    assign bus.ASCII_Out   = r_ascii;
    assign bus.ASCII_Valid = r_valid;
    assign bus.Done        = r_done;

endmodule

`default_nettype wire
